// File: rtl/button_press_cmd_if.sv
// Command handshake bundle between button_press_cmd and its consumer.
//   o_cmd_valid  : command available (driven by master)
//   i_cmd_ready  : consumer accepts command (driven by slave)
//   o_cmd_code   : button index 0..3
//   o_cmd_repeat : 0 = initial press, 1 = auto-repeat
//   o_cmd_drop   : one-cycle pulse when an event is discarded
interface button_press_cmd_if;
    logic       o_cmd_valid;
    logic       i_cmd_ready;
    logic [1:0] o_cmd_code;
    logic       o_cmd_repeat;
    logic       o_cmd_drop;

    modport master (
        output o_cmd_valid,
        output o_cmd_code,
        output o_cmd_repeat,
        output o_cmd_drop,
        input  i_cmd_ready
    );

    modport slave (
        input  o_cmd_valid,
        input  o_cmd_code,
        input  o_cmd_repeat,
        input  o_cmd_drop,
        output i_cmd_ready
    );
endinterface

// File: rtl/button_press_cmd.sv
// Turns debounced button levels into press / auto-repeat commands.
// A one-hot button generates a press command; holding it generates a first
// repeat after REPEAT_DELAY_MS and further repeats every REPEAT_RATE_MS.
// Commands leave through a single-entry valid/ready register; events that
// find the register full are discarded and flagged on o_cmd_drop.
//   i_clk_mhz  : clock, rising edge
//   i_rst_mhz  : synchronous active-high reset
//   i_btns_deb : 4 debounced, clock-synchronous button levels
//   cmd        : command handshake (master side)
module button_press_cmd #(
    parameter int unsigned FCLK            = 20000000,
    parameter int unsigned REPEAT_DELAY_MS = 500,
    parameter int unsigned REPEAT_RATE_MS  = 100
) (
    input  logic               i_clk_mhz,
    input  logic               i_rst_mhz,
    input  logic [3:0]         i_btns_deb,
    button_press_cmd_if.master cmd
);

    // 64-bit intermediate: FCLK * ms overflows 32 bits for default values.
    localparam logic [31:0] C_DELAY =
        32'((64'(FCLK) * 64'(REPEAT_DELAY_MS)) / 64'd1000);
    localparam logic [31:0] C_RATE =
        32'((64'(FCLK) * 64'(REPEAT_RATE_MS)) / 64'd1000);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_REPEAT,
        ST_WAIT_REL
    } state_t;

    state_t      s_state, s_state_nxt;
    logic [3:0]  s_btns_q;
    logic [3:0]  s_btn_lat, s_btn_lat_nxt;
    logic [31:0] s_timer, s_timer_nxt;

    logic        s_ev;
    logic [1:0]  s_ev_code;
    logic        s_ev_rep;

    logic        s_valid;
    logic [1:0]  s_code;
    logic        s_rep;
    logic        s_drop;

    function automatic logic [1:0] encode(input logic [3:0] onehot);
        logic [1:0] idx;
        idx = 2'd0;
        case (onehot)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    always_ff @(posedge i_clk_mhz) begin
        if (i_rst_mhz) begin
            s_btns_q  <= '0;
            s_state   <= ST_IDLE;
            s_timer   <= '0;
            s_btn_lat <= '0;
        end else begin
            s_btns_q  <= i_btns_deb;
            s_state   <= s_state_nxt;
            s_timer   <= s_timer_nxt;
            s_btn_lat <= s_btn_lat_nxt;
        end
    end

    always_comb begin
        s_state_nxt   = s_state;
        s_timer_nxt   = s_timer;
        s_btn_lat_nxt = s_btn_lat;
        s_ev          = 1'b0;
        s_ev_code     = encode(s_btn_lat);
        s_ev_rep      = 1'b0;
        case (s_state)
            ST_IDLE: begin
                s_timer_nxt = '0;
                if ($onehot(s_btns_q)) begin
                    s_ev          = 1'b1;
                    s_ev_code     = encode(s_btns_q);
                    s_btn_lat_nxt = s_btns_q;
                    s_state_nxt   = ST_HOLD;
                end else if (s_btns_q != '0) begin
                    s_state_nxt = ST_WAIT_REL;
                end
            end
            ST_HOLD, ST_REPEAT: begin
                // A change of buttons wins over a coinciding timer expiry.
                if (s_btns_q != s_btn_lat) begin
                    s_timer_nxt = '0;
                    s_state_nxt = (s_btns_q == '0) ? ST_IDLE : ST_WAIT_REL;
                end else if (s_timer == ((s_state == ST_HOLD) ? C_DELAY - 32'd1
                                                              : C_RATE - 32'd1)) begin
                    s_ev        = 1'b1;
                    s_ev_rep    = 1'b1;
                    s_timer_nxt = '0;
                    s_state_nxt = ST_REPEAT;
                end else begin
                    s_timer_nxt = s_timer + 32'd1;
                end
            end
            ST_WAIT_REL: begin
                s_timer_nxt = '0;
                if (s_btns_q == '0) begin
                    s_state_nxt = ST_IDLE;
                end
            end
            default: begin
                s_timer_nxt = '0;
                s_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Single-entry output register. A transfer in the same cycle as a new
    // event frees the slot, so the event loads without a valid bubble.
    always_ff @(posedge i_clk_mhz) begin
        if (i_rst_mhz) begin
            s_valid <= 1'b0;
            s_code  <= '0;
            s_rep   <= 1'b0;
            s_drop  <= 1'b0;
        end else begin
            s_drop <= 1'b0;
            if (s_ev) begin
                if (!s_valid || cmd.i_cmd_ready) begin
                    s_valid <= 1'b1;
                    s_code  <= s_ev_code;
                    s_rep   <= s_ev_rep;
                end else begin
                    s_drop <= 1'b1;
                end
            end else if (cmd.i_cmd_ready) begin
                s_valid <= 1'b0;
            end
        end
    end

    assign cmd.o_cmd_valid  = s_valid;
    assign cmd.o_cmd_code   = s_code;
    assign cmd.o_cmd_repeat = s_rep;
    assign cmd.o_cmd_drop   = s_drop;

endmodule

// File: tb/tb_button_press_cmd.sv
// Bench for button_press_cmd: directed scenarios plus randomized buttons,
// back-pressure and resets, compared every cycle against a reference model
// built from hold-age arithmetic and a one-slot output buffer.
module tb_button_press_cmd;

    localparam int unsigned FCLK    = 10000;
    localparam int unsigned DLY_MS  = 5;
    localparam int unsigned RATE_MS = 2;
    localparam int C_DELAY = int'(FCLK * DLY_MS / 1000);
    localparam int C_RATE  = int'(FCLK * RATE_MS / 1000);

    logic       clk;
    logic       rst;
    logic [3:0] btns;
    int         n_chk;
    int         n_err;
    bit         chk_en;

    button_press_cmd_if cmd_if();

    button_press_cmd #(
        .FCLK            (FCLK),
        .REPEAT_DELAY_MS (DLY_MS),
        .REPEAT_RATE_MS  (RATE_MS)
    ) dut (
        .i_clk_mhz  (clk),
        .i_rst_mhz  (rst),
        .i_btns_deb (btns),
        .cmd        (cmd_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [3:0] m_q;
    int         m_btn;
    int         m_age;
    bit         m_block;
    bit         m_valid;
    logic [1:0] m_code;
    bit         m_rep;
    bit         m_drop;

    function automatic int onehot_idx(input logic [3:0] v);
        int cnt;
        int idx;
        cnt = 0;
        idx = -1;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) begin
                cnt++;
                idx = i;
            end
        end
        return (cnt == 1) ? idx : -1;
    endfunction

    task automatic model_step();
        int         idx;
        bit         ev;
        logic [1:0] ev_code;
        bit         ev_rep;
        bit         xfer;
        if (rst) begin
            m_q = '0; m_btn = -1; m_age = 0; m_block = 0;
            m_valid = 0; m_code = '0; m_rep = 0; m_drop = 0;
            return;
        end
        ev = 0; ev_code = '0; ev_rep = 0;
        idx = onehot_idx(m_q);
        if (m_block) begin
            if (m_q == '0) m_block = 0;
        end else if (m_btn < 0) begin
            if (idx >= 0) begin
                ev = 1; ev_code = 2'(idx); m_btn = idx; m_age = 0;
            end else if (m_q != '0) begin
                m_block = 1;
            end
        end else if (idx != m_btn) begin
            m_btn = -1;
            if (m_q != '0) m_block = 1;
        end else begin
            m_age++;
            if (m_age >= C_DELAY && (m_age - C_DELAY) % C_RATE == 0) begin
                ev = 1; ev_code = 2'(m_btn); ev_rep = 1;
            end
        end
        xfer = m_valid && cmd_if.i_cmd_ready;
        m_drop = 0;
        if (ev) begin
            if (!m_valid || xfer) begin
                m_valid = 1; m_code = ev_code; m_rep = ev_rep;
            end else begin
                m_drop = 1;
            end
        end else if (xfer) begin
            m_valid = 0;
        end
        m_q = btns;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check_eq("model_valid", 32'(cmd_if.o_cmd_valid), 32'(m_valid));
            if (m_valid) begin
                check_eq("model_code", 32'(cmd_if.o_cmd_code), 32'(m_code));
                check_eq("model_repeat", 32'(cmd_if.o_cmd_repeat), 32'(m_rep));
            end
            check_eq("model_drop", 32'(cmd_if.o_cmd_drop), 32'(m_drop));
        end
    end

    // ---------------- directed and random stimulus ----------------
    task automatic after_edges(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        after_edges(2);
        rst = 1'b0;
    endtask

    initial begin
        int ev_k[$];
        bit ev_rep[$];
        int exp_k[5];
        int drops;
        int drop_k;
        int bad;
        int hold_left;
        int r;

        n_chk = 0; n_err = 0; chk_en = 0;
        rst = 1'b1; btns = '0; cmd_if.i_cmd_ready = 1'b0;
        after_edges(2);
        check_eq("rst_valid", 32'(cmd_if.o_cmd_valid), 0);
        check_eq("rst_code", 32'(cmd_if.o_cmd_code), 0);
        check_eq("rst_repeat", 32'(cmd_if.o_cmd_repeat), 0);
        check_eq("rst_drop", 32'(cmd_if.o_cmd_drop), 0);
        chk_en = 1;
        rst = 1'b0;
        cmd_if.i_cmd_ready = 1'b1;
        after_edges(3);

        // Press latency: valid two edges after the input change, one cycle.
        btns = 4'b0100;
        after_edges(1);
        check_eq("lat_edge1_valid", 32'(cmd_if.o_cmd_valid), 0);
        after_edges(1);
        check_eq("lat_edge2_valid", 32'(cmd_if.o_cmd_valid), 1);
        check_eq("lat_code", 32'(cmd_if.o_cmd_code), 2);
        check_eq("lat_repeat", 32'(cmd_if.o_cmd_repeat), 0);
        after_edges(1);
        check_eq("lat_one_cycle", 32'(cmd_if.o_cmd_valid), 0);
        btns = '0;
        after_edges(4);

        // Auto-repeat cadence while held, nothing after release.
        exp_k[0] = 2;
        exp_k[1] = 2 + C_DELAY;
        for (int i = 2; i < 5; i++) exp_k[i] = exp_k[i-1] + C_RATE;
        btns = 4'b0001;
        for (int k = 1; k <= 140; k++) begin
            after_edges(1);
            if (k == 120) btns = '0;
            if (cmd_if.o_cmd_valid) begin
                ev_k.push_back(k);
                ev_rep.push_back(cmd_if.o_cmd_repeat);
                check_eq("rep_code", 32'(cmd_if.o_cmd_code), 0);
            end
        end
        check_eq("rep_count", 32'(ev_k.size()), 5);
        for (int i = 0; i < 5 && i < ev_k.size(); i++) begin
            check_eq("rep_time", 32'(ev_k[i]), 32'(exp_k[i]));
            check_eq("rep_flag", 32'(ev_rep[i]), (i == 0) ? 32'd0 : 32'd1);
        end

        // Back-pressure: press held stable, repeat dropped, cadence kept.
        do_reset();
        cmd_if.i_cmd_ready = 1'b0;
        btns = 4'b1000;
        drops = 0; drop_k = -1; bad = 0;
        for (int k = 1; k <= 85; k++) begin
            after_edges(1);
            if (k == 70) btns = '0;
            if (cmd_if.o_cmd_drop) begin
                drops++;
                if (drop_k < 0) drop_k = k;
            end
            if (k >= 2 && (cmd_if.o_cmd_valid !== 1'b1 || cmd_if.o_cmd_code !== 2'd3
                           || cmd_if.o_cmd_repeat !== 1'b0)) bad++;
        end
        check_eq("bp_drop_count", 32'(drops), 1);
        check_eq("bp_drop_time", 32'(drop_k), 32'(2 + C_DELAY));
        check_eq("bp_held_stable", 32'(bad), 0);
        cmd_if.i_cmd_ready = 1'b1;
        after_edges(1);
        check_eq("bp_drained", 32'(cmd_if.o_cmd_valid), 0);

        // Multi-button input never produces a command until full release.
        after_edges(2);
        bad = 0;
        btns = 4'b0011;
        for (int k = 0; k < 6; k++) begin
            after_edges(1);
            if (cmd_if.o_cmd_valid) bad++;
        end
        btns = 4'b0010;
        for (int k = 0; k < 6; k++) begin
            after_edges(1);
            if (cmd_if.o_cmd_valid) bad++;
        end
        check_eq("multi_no_cmd", 32'(bad), 0);
        btns = '0;
        after_edges(3);
        btns = 4'b0010;
        after_edges(2);
        check_eq("multi_then_valid", 32'(cmd_if.o_cmd_valid), 1);
        check_eq("multi_then_code", 32'(cmd_if.o_cmd_code), 1);
        btns = '0;
        after_edges(4);

        // Reset mid-hold with a pending command, button still held.
        cmd_if.i_cmd_ready = 1'b0;
        btns = 4'b0010;
        after_edges(30);
        check_eq("rh_pending", 32'(cmd_if.o_cmd_valid), 1);
        rst = 1'b1;
        after_edges(1);
        rst = 1'b0;
        check_eq("rh_valid_cleared", 32'(cmd_if.o_cmd_valid), 0);
        check_eq("rh_code_cleared", 32'(cmd_if.o_cmd_code), 0);
        after_edges(1);
        check_eq("rh_edge1_valid", 32'(cmd_if.o_cmd_valid), 0);
        after_edges(1);
        check_eq("rh_new_valid", 32'(cmd_if.o_cmd_valid), 1);
        check_eq("rh_new_code", 32'(cmd_if.o_cmd_code), 1);
        check_eq("rh_new_repeat", 32'(cmd_if.o_cmd_repeat), 0);
        cmd_if.i_cmd_ready = 1'b1;
        btns = '0;
        after_edges(4);

        // Release on the exact expiry cycle: no repeat, back to idle.
        btns = 4'b0100;
        after_edges(2);
        check_eq("exp_press", 32'(cmd_if.o_cmd_valid), 1);
        bad = 0;
        for (int k = 3; k <= 60; k++) begin
            if (k == C_DELAY + 1) btns = '0;
            after_edges(1);
            if (cmd_if.o_cmd_valid) bad++;
        end
        check_eq("exp_no_repeat", 32'(bad), 0);
        btns = 4'b0100;
        after_edges(2);
        check_eq("exp_idle_valid", 32'(cmd_if.o_cmd_valid), 1);
        check_eq("exp_idle_repeat", 32'(cmd_if.o_cmd_repeat), 0);
        btns = '0;
        after_edges(4);

        // Randomized buttons, back-pressure and occasional reset.
        hold_left = 0;
        for (int c = 0; c < 4000; c++) begin
            if (hold_left == 0) begin
                r = int'($urandom_range(0, 9));
                if (r < 3)      btns = '0;
                else if (r < 8) btns = 4'b0001 << $urandom_range(0, 3);
                else            btns = 4'($urandom_range(0, 15));
                hold_left = int'($urandom_range(1, 130));
            end
            hold_left--;
            cmd_if.i_cmd_ready = ($urandom_range(0, 9) < 7);
            rst = ($urandom_range(0, 799) == 0);
            after_edges(1);
        end
        rst = 1'b0;
        after_edges(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
